// File: rtl/rv32_wb_pkg.sv
// Shared write-back stage definitions:
// result source codes and counter CSR addresses.
package rv32_wb_pkg;

  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'd0,
    WB_SEL_LOAD = 3'd1,
    WB_SEL_PC4  = 3'd2,
    WB_SEL_IMM  = 3'd3,
    WB_SEL_CSR  = 3'd4
  } wb_sel_e;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM/WB consumer bundle: WB-stage inputs plus
// register-file, CSR, bypass and counter outputs.
interface wb_retire_unit_if #(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 64
);
  logic                     WB_valid;
  logic [2:0]               WB_register_file_write_data_select;
  logic [XLEN-1:0]          WB_alu_result;
  logic [XLEN-1:0]          WB_byte_enable_logic_register_file_write_data;
  logic [XLEN-1:0]          WB_pc_plus_4;
  logic [XLEN-1:0]          WB_imm;
  logic [XLEN-1:0]          WB_csr_read_data;
  logic                     WB_register_write_enable;
  logic                     WB_csr_write_enable;
  logic [4:0]               WB_rd;
  logic [11:0]              WB_raw_imm;

  logic                     rf_write_enable;
  logic [4:0]               rf_write_addr;
  logic [XLEN-1:0]          rf_write_data;
  logic                     csr_write_enable;
  logic [11:0]              csr_write_addr;
  logic [XLEN-1:0]          csr_write_data;
  logic                     bypass_valid;
  logic [4:0]               bypass_rd;
  logic [XLEN-1:0]          bypass_data;
  logic [COUNTER_WIDTH-1:0] mcycle;
  logic [COUNTER_WIDTH-1:0] minstret;

  modport master (
    output WB_valid, WB_register_file_write_data_select,
    output WB_alu_result,
    output WB_byte_enable_logic_register_file_write_data,
    output WB_pc_plus_4, WB_imm, WB_csr_read_data,
    output WB_register_write_enable, WB_csr_write_enable,
    output WB_rd, WB_raw_imm,
    input  rf_write_enable, rf_write_addr, rf_write_data,
    input  csr_write_enable, csr_write_addr, csr_write_data,
    input  bypass_valid, bypass_rd, bypass_data,
    input  mcycle, minstret
  );

  modport slave (
    input  WB_valid, WB_register_file_write_data_select,
    input  WB_alu_result,
    input  WB_byte_enable_logic_register_file_write_data,
    input  WB_pc_plus_4, WB_imm, WB_csr_read_data,
    input  WB_register_write_enable, WB_csr_write_enable,
    input  WB_rd, WB_raw_imm,
    output rf_write_enable, rf_write_addr, rf_write_data,
    output csr_write_enable, csr_write_addr, csr_write_data,
    output bypass_valid, bypass_rd, bypass_data,
    output mcycle, minstret
  );
endinterface

// File: rtl/wb_counter64.sv
// Wrapping counter with independent half-word loads;
// a load takes priority over the increment.
module wb_counter64 #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  input  logic           wr_lo,
  input  logic           wr_hi,
  input  logic [W/2-1:0] wdata,
  output logic [W-1:0]   count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (wr_lo) begin
      r_count[W/2-1:0] <= wdata;
    end else if (wr_hi) begin
      r_count[W-1:W/2] <= wdata;
    end else if (inc) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;
endmodule

// File: rtl/wb_retire_unit.sv
// Write-back/retire: register-file and CSR write strobes,
// one-cycle rd bypass, and the mcycle/minstret counters.
module wb_retire_unit
  import rv32_wb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  wb_retire_unit_if.slave  bus
);
  logic [XLEN-1:0] w_sel_data;
  logic            w_rf_we;
  logic            w_csr_we;
  logic            w_mcyc_lo;
  logic            w_mcyc_hi;
  logic            w_mret_lo;
  logic            w_mret_hi;

  logic            r_bp_valid;
  logic [4:0]      r_bp_rd;
  logic [XLEN-1:0] r_bp_data;

  always_comb begin
    w_sel_data = '0;
    case (wb_sel_e'(bus.WB_register_file_write_data_select))
      WB_SEL_ALU:  w_sel_data = bus.WB_alu_result;
      WB_SEL_LOAD: w_sel_data =
        bus.WB_byte_enable_logic_register_file_write_data;
      WB_SEL_PC4:  w_sel_data = bus.WB_pc_plus_4;
      WB_SEL_IMM:  w_sel_data = bus.WB_imm;
      WB_SEL_CSR:  w_sel_data = bus.WB_csr_read_data;
      default:     w_sel_data = '0;
    endcase
  end

  assign w_rf_we = bus.WB_valid & bus.WB_register_write_enable
                 & (|bus.WB_rd);
  assign w_csr_we = bus.WB_valid & bus.WB_csr_write_enable;

  assign bus.rf_write_enable  = w_rf_we;
  assign bus.rf_write_addr    = bus.WB_rd;
  assign bus.rf_write_data    = w_sel_data;
  assign bus.csr_write_enable = w_csr_we;
  assign bus.csr_write_addr   = bus.WB_raw_imm;
  assign bus.csr_write_data   = bus.WB_alu_result;

  assign w_mcyc_lo = w_csr_we & (bus.WB_raw_imm == CSR_MCYCLE);
  assign w_mcyc_hi = w_csr_we & (bus.WB_raw_imm == CSR_MCYCLEH);
  assign w_mret_lo = w_csr_we & (bus.WB_raw_imm == CSR_MINSTRET);
  assign w_mret_hi = w_csr_we & (bus.WB_raw_imm == CSR_MINSTRETH);

  // A CSR write to mcycle still retires, so minstret counts it.
  wb_counter64 #(.W(COUNTER_WIDTH)) u_mcycle (
    .clk   (clk),
    .rst_n (reset),
    .inc   (1'b1),
    .wr_lo (w_mcyc_lo),
    .wr_hi (w_mcyc_hi),
    .wdata (bus.WB_alu_result),
    .count (bus.mcycle)
  );

  wb_counter64 #(.W(COUNTER_WIDTH)) u_minstret (
    .clk   (clk),
    .rst_n (reset),
    .inc   (bus.WB_valid),
    .wr_lo (w_mret_lo),
    .wr_hi (w_mret_hi),
    .wdata (bus.WB_alu_result),
    .count (bus.minstret)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bp_valid <= 1'b0;
      r_bp_rd    <= '0;
      r_bp_data  <= '0;
    end else begin
      r_bp_valid <= w_rf_we;
      r_bp_rd    <= bus.WB_rd;
      r_bp_data  <= w_sel_data;
    end
  end

  assign bus.bypass_valid = r_bp_valid;
  assign bus.bypass_rd    = r_bp_rd;
  assign bus.bypass_data  = r_bp_data;
endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_wb_retire_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [63:0] m_mcycle, m_minstret;
  logic        m_bv;
  logic [4:0]  m_brd;
  logic [31:0] m_bd;

  wb_retire_unit_if #(.XLEN(32), .COUNTER_WIDTH(64)) bus ();

  wb_retire_unit #(.XLEN(32), .COUNTER_WIDTH(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data();
    logic [31:0] src [8];
    src = '{bus.WB_alu_result,
            bus.WB_byte_enable_logic_register_file_write_data,
            bus.WB_pc_plus_4, bus.WB_imm, bus.WB_csr_read_data,
            32'h0, 32'h0, 32'h0};
    return src[bus.WB_register_file_write_data_select];
  endfunction

  function automatic logic exp_we();
    return bus.WB_valid && bus.WB_register_write_enable
        && bus.WB_rd != 5'd0;
  endfunction

  task automatic model_clear();
    m_mcycle = 0; m_minstret = 0;
    m_bv = 0; m_brd = 0; m_bd = 0;
  endtask

  // What one rising edge does, from the architectural rules.
  task automatic model_edge();
    logic cw;
    logic [11:0] a;
    logic [31:0] d;
    cw = bus.WB_valid && bus.WB_csr_write_enable;
    a = bus.WB_raw_imm;
    d = bus.WB_alu_result;
    if (cw && a == 12'hB00) m_mcycle[31:0] = d;
    else if (cw && a == 12'hB80) m_mcycle[63:32] = d;
    else m_mcycle = m_mcycle + 64'd1;
    if (cw && a == 12'hB02) m_minstret[31:0] = d;
    else if (cw && a == 12'hB82) m_minstret[63:32] = d;
    else if (bus.WB_valid) m_minstret = m_minstret + 64'd1;
    m_bv = exp_we();
    m_brd = bus.WB_rd;
    m_bd = exp_data();
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [4:0] rd, input logic rwe,
                       input logic cwe, input logic [11:0] addr,
                       input logic [31:0] alu,
                       input logic [31:0] ld);
    bus.WB_valid = v;
    bus.WB_register_file_write_data_select = sel;
    bus.WB_rd = rd;
    bus.WB_register_write_enable = rwe;
    bus.WB_csr_write_enable = cwe;
    bus.WB_raw_imm = addr;
    bus.WB_alu_result = alu;
    bus.WB_byte_enable_logic_register_file_write_data = ld;
    bus.WB_pc_plus_4 = $urandom;
    bus.WB_imm = $urandom;
    bus.WB_csr_read_data = $urandom;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    nop();
    #1;
    checks += 4;
    if (bus.mcycle !== 64'd0) begin
      errors++;
      $display("FAIL reset_mcycle: got %h exp 0", bus.mcycle);
    end
    if (bus.minstret !== 64'd0) begin
      errors++;
      $display("FAIL reset_minstret: got %h exp 0", bus.minstret);
    end
    if (bus.bypass_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_bpv: got %b exp 0", bus.bypass_valid);
    end
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_rfwe: got %b exp 0", bus.rf_write_enable);
    end
  endtask

  task automatic test_idle();
    model_clear();
    rst_n = 1'b1;
    nop();
    repeat (10) step();
    checks += 4;
    if (bus.mcycle !== 64'd10 || m_mcycle !== 64'd10) begin
      errors++;
      $display("FAIL idle_mcycle: got %h exp 10", bus.mcycle);
    end
    if (bus.minstret !== 64'd0) begin
      errors++;
      $display("FAIL idle_minstret: got %h exp 0", bus.minstret);
    end
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_rfwe: got %b exp 0", bus.rf_write_enable);
    end
    if (bus.bypass_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_bpv: got %b exp 0", bus.bypass_valid);
    end
  endtask

  task automatic test_load();
    drive(1, 3'd1, 5'd5, 1, 0, 12'h0, $urandom, 32'hFFFF_FF80);
    #1;
    checks += 3;
    if (bus.rf_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL load_rfwe: got %b exp 1", bus.rf_write_enable);
    end
    if (bus.rf_write_addr !== 5'd5) begin
      errors++;
      $display("FAIL load_addr: got %0d exp 5", bus.rf_write_addr);
    end
    if (bus.rf_write_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL load_data: got %h exp ffffff80",
               bus.rf_write_data);
    end
    step();
    nop();
    checks += 4;
    if (bus.bypass_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_bpv: got %b exp 1", bus.bypass_valid);
    end
    if (bus.bypass_rd !== 5'd5) begin
      errors++;
      $display("FAIL load_bprd: got %0d exp 5", bus.bypass_rd);
    end
    if (bus.bypass_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL load_bpdata: got %h exp ffffff80",
               bus.bypass_data);
    end
    if (bus.minstret !== 64'd1) begin
      errors++;
      $display("FAIL load_minstret: got %h exp 1", bus.minstret);
    end
  endtask

  task automatic test_suppress();
    drive(1, 3'd0, 5'd0, 1, 0, 12'h0, $urandom, $urandom);
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL x0_rfwe: got %b exp 0", bus.rf_write_enable);
    end
    step();
    checks++;
    if (bus.bypass_valid !== 1'b0) begin
      errors++;
      $display("FAIL x0_bpv: got %b exp 0", bus.bypass_valid);
    end
    drive(0, 3'd0, 5'd7, 1, 1, 12'hB02, $urandom, $urandom);
    #1;
    checks += 2;
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL bub_rfwe: got %b exp 0", bus.rf_write_enable);
    end
    if (bus.csr_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL bub_csrwe: got %b exp 0", bus.csr_write_enable);
    end
    step();
    checks += 2;
    if (bus.minstret !== 64'd2 || m_minstret !== 64'd2) begin
      errors++;
      $display("FAIL bub_minstret: got %h exp 2", bus.minstret);
    end
    if (bus.bypass_valid !== 1'b0) begin
      errors++;
      $display("FAIL bub_bpv: got %b exp 0", bus.bypass_valid);
    end
  endtask

  task automatic test_carry();
    drive(1, 3'd4, 5'd0, 0, 1, 12'hB02, 32'hFFFF_FFFF, 0);
    #1;
    checks += 3;
    if (bus.csr_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL carry_csrwe: got %b exp 1", bus.csr_write_enable);
    end
    if (bus.csr_write_addr !== 12'hB02) begin
      errors++;
      $display("FAIL carry_csraddr: got %h exp b02", bus.csr_write_addr);
    end
    if (bus.csr_write_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL carry_csrdata: got %h exp ffffffff",
               bus.csr_write_data);
    end
    step();
    drive(1, 3'd0, 5'd0, 0, 0, 0, 0, 0);
    step();
    checks += 2;
    if (bus.minstret !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL carry_first: got %h exp 100000000", bus.minstret);
    end
    if (bus.mcycle !== m_mcycle) begin
      errors++;
      $display("FAIL carry_mcycle1: got %h exp %h", bus.mcycle, m_mcycle);
    end
    step();
    nop();
    checks += 2;
    if (bus.minstret !== 64'h1_0000_0001) begin
      errors++;
      $display("FAIL carry_second: got %h exp 100000001", bus.minstret);
    end
    if (bus.mcycle !== m_mcycle) begin
      errors++;
      $display("FAIL carry_mcycle2: got %h exp %h", bus.mcycle, m_mcycle);
    end
  endtask

  task automatic test_csr_write();
    logic [63:0] ret0;
    ret0 = m_minstret;
    drive(1, 3'd4, 5'd0, 0, 1, 12'hB00, 32'h1234, 0);
    step();
    nop();
    checks += 2;
    if (bus.mcycle[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL wr_mcycle: got %h exp 1234", bus.mcycle[31:0]);
    end
    if (bus.minstret !== ret0 + 64'd1) begin
      errors++;
      $display("FAIL wr_minstret: got %h exp %h", bus.minstret,
               ret0 + 64'd1);
    end
    step();
    checks++;
    if (bus.mcycle[31:0] !== 32'h1235) begin
      errors++;
      $display("FAIL wr_mcycle_next: got %h exp 1235", bus.mcycle[31:0]);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 3'd0, 5'd9, 1, 1, 12'hB00, 32'h50, 0);
    step();
    nop();
    checks += 2;
    if (bus.mcycle !== 64'h50) begin
      errors++;
      $display("FAIL ar_pre_mcycle: got %h exp 50", bus.mcycle);
    end
    if (bus.bypass_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre_bpv: got %b exp 1", bus.bypass_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.mcycle !== 64'd0) begin
      errors++;
      $display("FAIL ar_mcycle: got %h exp 0", bus.mcycle);
    end
    if (bus.minstret !== 64'd0) begin
      errors++;
      $display("FAIL ar_minstret: got %h exp 0", bus.minstret);
    end
    if (bus.bypass_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_bpv: got %b exp 0", bus.bypass_valid);
    end
    if (bus.bypass_rd !== 5'd0) begin
      errors++;
      $display("FAIL ar_bprd: got %0d exp 0", bus.bypass_rd);
    end
    if (bus.bypass_data !== 32'd0) begin
      errors++;
      $display("FAIL ar_bpdata: got %h exp 0", bus.bypass_data);
    end
    #3 rst_n = 1'b1;
    model_clear();
    step();
    checks++;
    if (bus.mcycle !== 64'd1) begin
      errors++;
      $display("FAIL ar_resume: got %h exp 1", bus.mcycle);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [5];
    addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h300};
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
            addrs[$urandom_range(0, 4)], $urandom, $urandom);
      #1;
      checks += 3;
      if (bus.rf_write_enable !== exp_we()) begin
        errors++;
        $display("FAIL rnd_rfwe[%0d]: got %b exp %b", i,
                 bus.rf_write_enable, exp_we());
      end
      if (bus.rf_write_data !== exp_data()) begin
        errors++;
        $display("FAIL rnd_rfdata[%0d]: got %h exp %h", i,
                 bus.rf_write_data, exp_data());
      end
      if (bus.csr_write_enable !==
          (bus.WB_valid & bus.WB_csr_write_enable)) begin
        errors++;
        $display("FAIL rnd_csrwe[%0d]: got %b", i, bus.csr_write_enable);
      end
      step();
      checks += 4;
      if (bus.mcycle !== m_mcycle) begin
        errors++;
        $display("FAIL rnd_mcycle[%0d]: got %h exp %h", i,
                 bus.mcycle, m_mcycle);
      end
      if (bus.minstret !== m_minstret) begin
        errors++;
        $display("FAIL rnd_minstret[%0d]: got %h exp %h", i,
                 bus.minstret, m_minstret);
      end
      if (bus.bypass_valid !== m_bv) begin
        errors++;
        $display("FAIL rnd_bpv[%0d]: got %b exp %b", i,
                 bus.bypass_valid, m_bv);
      end
      if ({bus.bypass_rd, bus.bypass_data} !== {m_brd, m_bd}) begin
        errors++;
        $display("FAIL rnd_bp[%0d]: got %h/%h exp %h/%h", i,
                 bus.bypass_rd, bus.bypass_data, m_brd, m_bd);
      end
    end
  endtask

  initial begin
    nop();
    #12;
    test_reset();
    test_idle();
    test_load();
    test_suppress();
    test_carry();
    test_csr_write();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
